vip_amba_apb_completer_regfile: RTL

//  APB4 completer (slave) end of the VIP APB link. Consumes the PSELx/PENABLE/PWRITE/PADDR/PWDATA/PSTRB/PPROT

---
 rtl/vip_amba_apb_completer_regfile.sv | 114 +++++++++++
 1 files changed

// File: rtl/vip_amba_apb_completer_regfile.sv
// rtl/vip_amba_apb_completer_regfile.sv - APB4 completer backed by a word-addressed register file
module vip_amba_apb_completer_regfile #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter int                       DATA_STROBE   = DATA_WIDTH / 8,
  parameter int                       NUM_REGS      = 16,
  parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDR     = '0,
  parameter int                       WAIT_STATES   = 0,
  parameter int                       PROT_REG_IDX  = 0
) (
  input  logic                     PCLK,
  input  logic                     PRESETn,
  input  logic                     PSELx,
  input  logic                     PENABLE,
  input  logic                     PWRITE,
  input  logic [ADDRESS_WIDTH-1:0] PADDR,
  input  logic [DATA_WIDTH-1:0]    PWDATA,
  input  logic [DATA_STROBE-1:0]   PSTRB,
  input  logic [2:0]               PPROT,
  output logic                     PREADY,
  output logic [DATA_WIDTH-1:0]    PRDATA,
  output logic                     PSLVERR
);

  localparam int                       LSB        = $clog2(DATA_STROBE);
  localparam int                       IDX_W      = $clog2(NUM_REGS);
  localparam logic [ADDRESS_WIDTH-1:0] SPAN       = ADDRESS_WIDTH'(NUM_REGS * DATA_STROBE);
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = ADDRESS_WIDTH'(DATA_STROBE - 1);
  localparam logic [IDX_W-1:0]         PROT_IDX   = IDX_W'(PROT_REG_IDX);
  localparam logic [3:0]               WAIT_INIT  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t                  state;
  logic [3:0]              wait_cnt;
  logic [IDX_W-1:0]        lat_idx;
  logic                    lat_write;
  logic                    lat_err;
  logic [DATA_WIDTH-1:0]   regs [NUM_REGS];

  logic [ADDRESS_WIDTH-1:0] offset;
  logic [IDX_W-1:0]         dec_idx;
  logic                     dec_err;
  logic                     unused_pprot;

  // Out-of-range addresses are rejected before the index is used, so no aliasing
  assign offset       = PADDR - BASE_ADDR;
  assign dec_idx      = offset[LSB +: IDX_W];
  assign dec_err      = (PADDR < BASE_ADDR) || (offset >= SPAN) ||
                        ((PADDR & ALIGN_MASK) != '0) ||
                        (PWRITE && (dec_idx == PROT_IDX) && !PPROT[0]);
  assign unused_pprot = ^PPROT[2:1];

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state     <= S_IDLE;
      wait_cnt  <= '0;
      lat_idx   <= '0;
      lat_write <= 1'b0;
      lat_err   <= 1'b0;
      PREADY    <= 1'b0;
      PRDATA    <= '0;
      PSLVERR   <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (PSELx && !PENABLE) begin
            lat_idx   <= dec_idx;
            lat_write <= PWRITE;
            lat_err   <= dec_err;
            if (WAIT_STATES == 0) begin
              state   <= S_DONE;
              PREADY  <= 1'b1;
              PSLVERR <= dec_err;
              PRDATA  <= (!PWRITE && !dec_err) ? regs[dec_idx] : '0;
            end else begin
              state    <= S_WAIT;
              wait_cnt <= WAIT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (!PSELx) begin
            state    <= S_IDLE;
            wait_cnt <= '0;
          end else if (PENABLE) begin
            if (wait_cnt == 4'd0) begin
              state   <= S_DONE;
              PREADY  <= 1'b1;
              PSLVERR <= lat_err;
              PRDATA  <= (!lat_write && !lat_err) ? regs[lat_idx] : '0;
            end else begin
              wait_cnt <= wait_cnt - 4'd1;
            end
          end
        end
        S_DONE: begin
          // Only a completed, error-free write touches the register file
          if (PSELx && PENABLE && lat_write && !lat_err) begin
            for (int i = 0; i < DATA_STROBE; i++)
              if (PSTRB[i]) regs[lat_idx][8*i +: 8] <= PWDATA[8*i +: 8];
          end
          state   <= S_IDLE;
          PREADY  <= 1'b0;
          PSLVERR <= 1'b0;
          PRDATA  <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
